// File: rtl/default_slave_rd_pkg.sv
// Shared AXI read-side types for the default (decode-error) slave.
// Width defaults come from the AXI_*_BITS defines when the includer has not set them.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

package default_slave_rd_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [0:0] {
    DEFSLV_IDLE  = 1'b0,
    DEFSLV_BURST = 1'b1
  } defslv_state_e;

endpackage

// File: rtl/default_slave_rd_if.sv
// AR/R channel bundle between the address decoder / R mux (master) and the default slave.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

interface default_slave_rd_if #(
  parameter int IDS_W  = `AXI_IDS_BITS,
  parameter int ADDR_W = `AXI_ADDR_BITS,
  parameter int LEN_W  = `AXI_LEN_BITS,
  parameter int DATA_W = `AXI_DATA_BITS
) ();

  logic [IDS_W-1:0]  ARID_DEF;
  logic [ADDR_W-1:0] ARADDR_DEF;
  logic [LEN_W-1:0]  ARLEN_DEF;
  logic [2:0]        ARSIZE_DEF;
  logic [1:0]        ARBURST_DEF;
  logic              ARVALID_DEF;
  logic              ARREADY_DEF;

  logic [IDS_W-1:0]  RID_DEF;
  logic [DATA_W-1:0] RDATA_DEF;
  logic [1:0]        RRESP_DEF;
  logic              RLAST_DEF;
  logic              RVALID_DEF;
  logic              RREADY_DEF;

  modport master (
    output ARID_DEF, ARADDR_DEF, ARLEN_DEF, ARSIZE_DEF, ARBURST_DEF, ARVALID_DEF,
    input  ARREADY_DEF,
    input  RID_DEF, RDATA_DEF, RRESP_DEF, RLAST_DEF, RVALID_DEF,
    output RREADY_DEF
  );

  modport slave (
    input  ARID_DEF, ARADDR_DEF, ARLEN_DEF, ARSIZE_DEF, ARBURST_DEF, ARVALID_DEF,
    output ARREADY_DEF,
    output RID_DEF, RDATA_DEF, RRESP_DEF, RLAST_DEF, RVALID_DEF,
    input  RREADY_DEF
  );

endinterface

// File: rtl/default_slave_rd.sv
// Read default slave: answers every unmapped AR with a full-length DECERR burst.
// Define DEFSLV_B2B_EN to accept the next AR on the last beat handshake (no idle gap).
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module default_slave_rd
  import default_slave_rd_pkg::*;
#(
  parameter int IDS_W  = `AXI_IDS_BITS,
  parameter int ADDR_W = `AXI_ADDR_BITS,
  parameter int LEN_W  = `AXI_LEN_BITS,
  parameter int DATA_W = `AXI_DATA_BITS,
  parameter int CNT_W  = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  default_slave_rd_if.slave bus,
  output logic [CNT_W-1:0] DECERR_CNT
);

  localparam logic [0:0] ST_IDLE  = DEFSLV_IDLE;
  localparam logic [0:0] ST_BURST = DEFSLV_BURST;

  logic [0:0]       state_q, state_d;
  logic [IDS_W-1:0] rid_q, rid_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] decerr_q, decerr_d;

  logic in_burst, last_beat, ar_ready, ar_hs, r_hs;

  // Address, size and burst type carry no meaning for an error response.
  logic unused_ar;
  assign unused_ar = ^{bus.ARADDR_DEF, bus.ARSIZE_DEF, bus.ARBURST_DEF};

  assign in_burst  = (state_q == ST_BURST);
  assign last_beat = in_burst && (cnt_q == '0);
  assign r_hs      = in_burst && bus.RREADY_DEF;
  assign ar_hs     = bus.ARVALID_DEF && ar_ready;

`ifdef DEFSLV_B2B_EN
  assign ar_ready = ARESETn && ((state_q == ST_IDLE) || (last_beat && bus.RREADY_DEF));
`else
  assign ar_ready = ARESETn && (state_q == ST_IDLE);
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d  = state_q;
    rid_d    = rid_q;
    cnt_d    = cnt_q;
    decerr_d = decerr_q;
    if (r_hs) begin
      if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
      else             state_d = ST_IDLE;
    end
    // A new request overrides the return to IDLE when it lands on the last beat.
    if (ar_hs) begin
      state_d = ST_BURST;
      rid_d   = bus.ARID_DEF;
      cnt_d   = bus.ARLEN_DEF;
      if (decerr_q != '1) decerr_d = decerr_q + CNT_W'(1);
    end
  end

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking assignments.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      rid_q    <= '0;
      cnt_q    <= '0;
      decerr_q <= '0;
    end else begin
      state_q  <= state_d;
      rid_q    <= rid_d;
      cnt_q    <= cnt_d;
      decerr_q <= decerr_d;
    end
  end

  assign bus.ARREADY_DEF = ar_ready;
  assign bus.RVALID_DEF  = in_burst;
  assign bus.RLAST_DEF   = last_beat;
  assign bus.RID_DEF     = in_burst ? rid_q : '0;
  assign bus.RRESP_DEF   = in_burst ? RESP_DECERR : RESP_OKAY;
  assign bus.RDATA_DEF   = '0;
  assign DECERR_CNT      = decerr_q;

endmodule

// File: tb/tb_default_slave_rd.sv
// Directed bench for default_slave_rd; expectations follow DEFSLV_B2B_EN when defined.
`timescale 1ns/1ps
module tb_default_slave_rd;

  logic        clk;
  logic        rst_n;
  logic [15:0] decerr_cnt;
  logic [1:0]  aux_cnt;
  int          n_checks;
  int          n_errors;

  default_slave_rd_if bus ();
  default_slave_rd_if aux ();

  default_slave_rd dut (
    .ACLK(clk), .ARESETn(rst_n), .bus(bus), .DECERR_CNT(decerr_cnt)
  );

  // Narrow counter instance so saturation is reachable in a few requests.
  default_slave_rd #(.CNT_W(2)) u_aux (
    .ACLK(clk), .ARESETn(rst_n), .bus(aux), .DECERR_CNT(aux_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int beats;
    int last_at;
    int prev;
    logic b2b;
`ifdef DEFSLV_B2B_EN
    b2b = 1'b1;
`else
    b2b = 1'b0;
`endif
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.ARID_DEF = '0; bus.ARADDR_DEF = 32'h0002_0000; bus.ARLEN_DEF = '0;
    bus.ARSIZE_DEF = 3'd2; bus.ARBURST_DEF = 2'b01; bus.ARVALID_DEF = 1'b0;
    bus.RREADY_DEF = 1'b0;
    aux.ARID_DEF = 8'h01; aux.ARADDR_DEF = 32'h0003_0000; aux.ARLEN_DEF = '0;
    aux.ARSIZE_DEF = 3'd2; aux.ARBURST_DEF = 2'b01; aux.ARVALID_DEF = 1'b0;
    aux.RREADY_DEF = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_arready", 32'(bus.ARREADY_DEF), 0);
    check("rst_rvalid",  32'(bus.RVALID_DEF), 0);
    check("rst_rlast",   32'(bus.RLAST_DEF), 0);
    check("rst_rid",     32'(bus.RID_DEF), 0);
    check("rst_rresp",   32'(bus.RRESP_DEF), 0);
    check("rst_rdata",   bus.RDATA_DEF, 0);
    check("rst_cnt",     32'(decerr_cnt), 0);
    rst_n = 1'b1;
    #1;
    check("idle_arready", 32'(bus.ARREADY_DEF), 1);

    // Test 1: single beat
    bus.ARID_DEF = 8'h15; bus.ARLEN_DEF = 4'd0; bus.ARVALID_DEF = 1'b1; bus.RREADY_DEF = 1'b1;
    tick();
    bus.ARVALID_DEF = 1'b0;
    #1;
    check("t1_rvalid", 32'(bus.RVALID_DEF), 1);
    check("t1_rid",    32'(bus.RID_DEF), 32'h15);
    check("t1_rresp",  32'(bus.RRESP_DEF), 3);
    check("t1_rlast",  32'(bus.RLAST_DEF), 1);
    check("t1_rdata",  bus.RDATA_DEF, 0);
    check("t1_cnt",    32'(decerr_cnt), 1);
    check("t1_arready_last", 32'(bus.ARREADY_DEF), 32'(b2b));
    tick();
    check("t1_rvalid_done", 32'(bus.RVALID_DEF), 0);
    check("t1_rid_zero",    32'(bus.RID_DEF), 0);
    check("t1_rresp_zero",  32'(bus.RRESP_DEF), 0);

    // Test 2: four beats with stalls between them
    bus.ARID_DEF = 8'h2A; bus.ARLEN_DEF = 4'd3; bus.ARVALID_DEF = 1'b1;
    tick();
    bus.ARVALID_DEF = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.RREADY_DEF = 1'b0;
      #1;
      check($sformatf("t2_b%0d_rlast", b), 32'(bus.RLAST_DEF), 32'(b == 3));
      check($sformatf("t2_b%0d_rid", b),   32'(bus.RID_DEF), 32'h2A);
      tick();
      check($sformatf("t2_b%0d_stall_rvalid", b), 32'(bus.RVALID_DEF), 1);
      check($sformatf("t2_b%0d_stall_rlast", b),  32'(bus.RLAST_DEF), 32'(b == 3));
      check($sformatf("t2_b%0d_stall_rid", b),    32'(bus.RID_DEF), 32'h2A);
      bus.RREADY_DEF = 1'b1;
      tick();
    end
    check("t2_rvalid_done", 32'(bus.RVALID_DEF), 0);
    check("t2_cnt", 32'(decerr_cnt), 2);

    // Test 3: AR held during a burst
    bus.ARID_DEF = 8'h33; bus.ARLEN_DEF = 4'd1; bus.ARVALID_DEF = 1'b1; bus.RREADY_DEF = 1'b1;
    tick();
    bus.ARID_DEF = 8'h44; bus.ARLEN_DEF = 4'd0;
    #1;
    check("t3_arready_mid", 32'(bus.ARREADY_DEF), 0);
    check("t3_rid_first",   32'(bus.RID_DEF), 32'h33);
    check("t3_rlast_first", 32'(bus.RLAST_DEF), 0);
    tick();
    check("t3_rlast_second",   32'(bus.RLAST_DEF), 1);
    check("t3_rid_second",     32'(bus.RID_DEF), 32'h33);
    check("t3_arready_second", 32'(bus.ARREADY_DEF), 32'(b2b));
    tick();
`ifndef DEFSLV_B2B_EN
    check("t3_idle_gap_rvalid",  32'(bus.RVALID_DEF), 0);
    check("t3_idle_gap_arready", 32'(bus.ARREADY_DEF), 1);
    tick();
`endif
    bus.ARVALID_DEF = 1'b0;
    #1;
    check("t3_new_rvalid", 32'(bus.RVALID_DEF), 1);
    check("t3_new_rid",    32'(bus.RID_DEF), 32'h44);
    check("t3_new_rlast",  32'(bus.RLAST_DEF), 1);
    check("t3_cnt",        32'(decerr_cnt), 4);
    tick();
    check("t3_done", 32'(bus.RVALID_DEF), 0);

    // Test 4: reset in the middle of an 8-beat burst
    bus.ARID_DEF = 8'h5A; bus.ARLEN_DEF = 4'd7; bus.ARVALID_DEF = 1'b1;
    tick();
    bus.ARVALID_DEF = 1'b0;
    tick(); tick();
    check("t4_beat2_rvalid", 32'(bus.RVALID_DEF), 1);
    check("t4_beat2_rlast",  32'(bus.RLAST_DEF), 0);
    rst_n = 1'b0;
    #1;
    check("t4_rst_arready", 32'(bus.ARREADY_DEF), 0);
    tick();
    check("t4_rst_rvalid", 32'(bus.RVALID_DEF), 0);
    check("t4_rst_rid",    32'(bus.RID_DEF), 0);
    check("t4_rst_cnt",    32'(decerr_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("t4_no_resume",   32'(bus.RVALID_DEF), 0);
    check("t4_arready_idle", 32'(bus.ARREADY_DEF), 1);

    // Test 6: maximum length burst
    bus.ARID_DEF = 8'h7E; bus.ARLEN_DEF = 4'd15; bus.ARVALID_DEF = 1'b1; bus.RREADY_DEF = 1'b1;
    tick();
    bus.ARVALID_DEF = 1'b0;
    #1;
    beats = 0;
    last_at = 0;
    for (int i = 0; i < 40 && bus.RVALID_DEF; i++) begin
      beats++;
      if (bus.RLAST_DEF) begin
        if (last_at == 0) last_at = beats;
      end
      tick();
    end
    check("t6_beats",   32'(beats), 16);
    check("t6_last_at", 32'(last_at), 16);
    check("t6_arready_after", 32'(bus.ARREADY_DEF), 1);
    check("t6_cnt", 32'(decerr_cnt), 1);

    // Test 5: saturation on the 2-bit counter instance (max 3)
    check("t5_aux_start", 32'(aux_cnt), 0);
    aux.ARVALID_DEF = 1'b1;
    tick();
    check("t5_aux_first", 32'(aux_cnt), 1);
    prev = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("t5_aux_mono_%0d", i), 32'(int'(aux_cnt) >= prev), 1);
      prev = int'(aux_cnt);
    end
    check("t5_aux_sat", 32'(aux_cnt), 3);
    aux.ARVALID_DEF = 1'b0;
    tick(); tick();
    check("t5_aux_hold", 32'(aux_cnt), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
